// File: rtl/grid_pkg.sv
// ----------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the grid RAM write-port arbiter.
//   GRID_ADDR_W / GRID_DATA_W / GRID_NUM_CELLS / GRID_FIFO_DEPTH
//       default geometry of the VGA cell grid and CPU write queue
//   grant_t        which requester owns the grid write port this cycle
//   sweep_state_t  clear-screen sweep engine state
// ----------------------------------------------------------------------------
package grid_pkg;

    localparam int GRID_ADDR_W     = 12;
    localparam int GRID_DATA_W     = 4;
    localparam int GRID_NUM_CELLS  = 4096;
    localparam int GRID_FIFO_DEPTH = 4;

    typedef enum logic {
        CPU   = 1'b0,
        CLEAR = 1'b1
    } grant_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/grid_wr_fifo.sv
// ----------------------------------------------------------------------------
// grid_wr_fifo
// Small synchronous FIFO that queues processor grid writes while the
// clear-screen sweep holds the write port.
// Ports:
//   clk, srst       clock and synchronous active-high reset
//   i_push, i_din   write side; a push while full is ignored
//   i_pop           read side; a pop while empty is ignored
//   o_dout          head entry, valid whenever o_empty is low
//   o_count         number of stored entries (0..DEPTH)
//   o_full, o_empty occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module grid_wr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CAP);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is read combinationally (first-word fall-through) so a queued
    // write can be granted on the very next edge after it was pushed.
    assign o_dout = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/grid_write_arbiter.sv
// ----------------------------------------------------------------------------
// grid_write_arbiter
// Shares the single write port of the VGA grid RAM between the processor and
// a built-in clear-screen sweep engine.
// Build option: define GRID_ARB_FIFO_EN to queue processor writes in a FIFO
// and arbitrate round-robin against the sweep. Without it, processor writes go
// straight to the output register and are refused while a sweep runs.
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   cpu_wren/addr/data     processor write request
//   cpu_ready              a write offered this cycle will be accepted
//   cpu_overflow           sticky: a write was offered while not ready
//   clear_req/clear_color  start a full-grid fill with clear_color
//   clear_busy             sweep in progress
//   wren_gridData, wraddress_gridData, data_gridData
//                          registered grid RAM write port
// ----------------------------------------------------------------------------
module grid_write_arbiter
    import grid_pkg::*;
#(
    parameter int ADDR_W     = GRID_ADDR_W,
    parameter int DATA_W     = GRID_DATA_W,
    parameter int GRID_CELLS = GRID_NUM_CELLS,
    parameter int FIFO_DEPTH = GRID_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    output logic              cpu_overflow,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              wren_gridData,
    output logic [ADDR_W-1:0] wraddress_gridData,
    output logic [DATA_W-1:0] data_gridData
);

    // One extra bit so the counter cannot wrap before matching the last cell.
    localparam int SWEEP_W = ADDR_W + 1;
    localparam logic [SWEEP_W-1:0] LAST_CELL = SWEEP_W'(GRID_CELLS - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("grid_write_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (GRID_CELLS < 1 || GRID_CELLS > (1 << ADDR_W)) begin : g_bad_cells
        $error("grid_write_arbiter: GRID_CELLS must be in 1..2**ADDR_W");
    end

    sweep_state_t      r_state;
    sweep_state_t      w_state_next;
    logic [SWEEP_W-1:0] r_sweep_cnt;
    logic [DATA_W-1:0] r_clear_color;
    logic              r_wren;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_overflow;

    logic              w_grant_cpu;
    logic              w_grant_clr;
    logic              w_overflow_set;
    logic              w_sweep_start;
    logic              w_sweep_last;
    logic [ADDR_W-1:0] w_cpu_addr;
    logic [DATA_W-1:0] w_cpu_data;

    assign clear_busy    = (r_state == SWEEP);
    assign w_sweep_start = (r_state == IDLE) && clear_req;
    assign w_sweep_last  = w_grant_clr && (r_sweep_cnt == LAST_CELL);

`ifdef GRID_ARB_FIFO_EN
    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FIFO_CAP = CNT_W'(FIFO_DEPTH);

    logic              w_fifo_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FIFO_W-1:0] w_fifo_dout;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_cpu_pend;
    logic              w_clr_pend;
    grant_t            r_last_grant;

    // Ready depends only on the registered count: a push at full is lost
    // even if the head pops in the same cycle.
    assign cpu_ready      = (w_fifo_count < FIFO_CAP);
    assign w_fifo_push    = cpu_wren && cpu_ready;
    assign w_overflow_set = cpu_wren && w_fifo_full;
    assign w_cpu_pend     = !w_fifo_empty;
    assign w_clr_pend     = clear_busy;
    assign w_cpu_addr     = w_fifo_dout[FIFO_W-1:DATA_W];
    assign w_cpu_data     = w_fifo_dout[DATA_W-1:0];

    grid_wr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .i_push  (w_fifo_push),
        .i_din   ({cpu_addr, cpu_data}),
        .i_pop   (w_grant_cpu),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Contended cycles go to whoever did not win the previous contention.
    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_clr = 1'b0;
        if (w_cpu_pend && w_clr_pend) begin
            if (r_last_grant == CLEAR) begin
                w_grant_cpu = 1'b1;
            end else begin
                w_grant_clr = 1'b1;
            end
        end else if (w_cpu_pend) begin
            w_grant_cpu = 1'b1;
        end else if (w_clr_pend) begin
            w_grant_clr = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= CLEAR;
        end else if (w_cpu_pend && w_clr_pend) begin
            r_last_grant <= w_grant_cpu ? CPU : CLEAR;
        end
    end
`else
    // No queue: the sweep owns the port outright and CPU writes are refused.
    assign cpu_ready      = !clear_busy;
    assign w_grant_cpu    = cpu_wren && cpu_ready;
    assign w_grant_clr    = clear_busy;
    assign w_overflow_set = cpu_wren && !cpu_ready;
    assign w_cpu_addr     = cpu_addr;
    assign w_cpu_data     = cpu_data;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (clear_req) w_state_next = SWEEP;
            SWEEP:   if (w_sweep_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sweep_cnt   <= '0;
            r_clear_color <= '0;
        end else if (w_sweep_start) begin
            r_sweep_cnt   <= '0;
            r_clear_color <= clear_color;
        end else if (w_grant_clr) begin
            r_sweep_cnt   <= r_sweep_cnt + 1'b1;
        end
    end

    // Address/data hold their last value on idle cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wren  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wren <= w_grant_cpu || w_grant_clr;
            if (w_grant_cpu) begin
                r_waddr <= w_cpu_addr;
                r_wdata <= w_cpu_data;
            end else if (w_grant_clr) begin
                r_waddr <= r_sweep_cnt[ADDR_W-1:0];
                r_wdata <= r_clear_color;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_overflow_set) begin
            r_overflow <= 1'b1;
        end
    end

    assign cpu_overflow       = r_overflow;
    assign wren_gridData      = r_wren;
    assign wraddress_gridData = r_waddr;
    assign data_gridData      = r_wdata;

endmodule

// File: tb/tb_grid_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_grid_write_arbiter
// Directed bench for grid_write_arbiter. Every grid write seen on the output
// port is logged on the falling edge; the directed sequence below drives the
// inputs and compares outputs and the log against hand-computed values.
// Expectations that differ with GRID_ARB_FIFO_EN are selected the same way.
// ----------------------------------------------------------------------------
module tb_grid_write_arbiter;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 4;
    localparam int GRID_CELLS = 4096;
    localparam int FIFO_DEPTH = 4;

`ifdef GRID_ARB_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic              cpu_overflow;
    logic              clear_req;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              wren_gridData;
    logic [ADDR_W-1:0] wraddress_gridData;
    logic [DATA_W-1:0] data_gridData;

    typedef struct {
        int   a;
        int   d;
        int   c;
        logic b;
    } wr_t;

    wr_t  log_q[$];
    wr_t  mon_e;
    int   cpu_a[$];
    int   n_sw;
    int   sw_err;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clock = ~clock;

    grid_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .GRID_CELLS (GRID_CELLS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_wren           (cpu_wren),
        .cpu_addr           (cpu_addr),
        .cpu_data           (cpu_data),
        .cpu_ready          (cpu_ready),
        .cpu_overflow       (cpu_overflow),
        .clear_req          (clear_req),
        .clear_color        (clear_color),
        .clear_busy         (clear_busy),
        .wren_gridData      (wren_gridData),
        .wraddress_gridData (wraddress_gridData),
        .data_gridData      (data_gridData)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wren_gridData === 1'b1) begin
            mon_e.a = int'(wraddress_gridData);
            mon_e.d = int'(data_gridData);
            mon_e.c = cyc;
            mon_e.b = clear_busy;
            log_q.push_back(mon_e);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clear_req = 1'b0;
        cpu_wren  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_sweep_end(input string tag);
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(clear_busy), 32'd0);
        tick();
    endtask

    // Split the log into sweep writes (data == color, must be 0,1,2,...) and
    // CPU writes (everything else, addresses kept in order).
    task automatic scan_log(input int color);
        n_sw   = 0;
        sw_err = 0;
        cpu_a.delete();
        foreach (log_q[i]) begin
            if (log_q[i].d == color) begin
                if (log_q[i].a != n_sw) sw_err++;
                n_sw++;
            end else begin
                cpu_a.push_back(log_q[i].a);
            end
        end
    endtask

    initial begin
        int start_cyc;
        int ready_low;
        int n;
        int exp_ovf[8];
        exp_ovf = '{32'h800, 32'h801, 32'h802, 32'h803, 32'h804, 32'h805, 32'h806, 32'h808};

        // ---- reset with clear_req and cpu_wren held high
        reset       = 1'b1;
        clear_req   = 1'b1;
        clear_color = 4'hF;
        cpu_wren    = 1'b1;
        cpu_addr    = 12'h3FF;
        cpu_data    = 4'h7;
        repeat (3) tick();
        check("rst_wren", 32'(wren_gridData), 0);
        check("rst_addr", 32'(wraddress_gridData), 0);
        check("rst_data", 32'(data_gridData), 0);
        check("rst_busy", 32'(clear_busy), 0);
        check("rst_ovf", 32'(cpu_overflow), 0);
        check("rst_ready", 32'(cpu_ready), 1);
        reset     = 1'b0;
        clear_req = 1'b0;
        cpu_wren  = 1'b0;
        tick();
        check("rst_no_write", log_q.size(), 0);
        check("rst_no_sweep", 32'(clear_busy), 0);

        // ---- single CPU write while idle
        log_q.delete();
        cpu_wren = 1'b1;
        cpu_addr = 12'h123;
        cpu_data = 4'h5;
        tick();
        cpu_wren = 1'b0;
`ifdef GRID_ARB_FIFO_EN
        check("cpu_lat_early", 32'(wren_gridData), 0);
        tick();
`endif
        check("cpu_wren", 32'(wren_gridData), 1);
        check("cpu_addr", 32'(wraddress_gridData), 32'h123);
        check("cpu_data", 32'(data_gridData), 32'h5);
        tick();
        check("cpu_one_cycle", 32'(wren_gridData), 0);
        check("cpu_addr_hold", 32'(wraddress_gridData), 32'h123);
        check("cpu_data_hold", 32'(data_gridData), 32'h5);
        check("cpu_log", log_q.size(), 1);

        // ---- uncontended clear, with a stray clear_req mid-sweep
        log_q.delete();
        clear_req   = 1'b1;
        clear_color = 4'h9;
        tick();
        start_cyc = cyc;
        clear_req = 1'b0;
        check("clr_busy_start", 32'(clear_busy), 1);
        check("clr_ready", 32'(cpu_ready), 32'(FIFO_EN));
        repeat (10) tick();
        clear_req   = 1'b1;
        clear_color = 4'h5;
        tick();
        clear_req   = 1'b0;
        clear_color = 4'h9;
        wait_sweep_end("clr");
        scan_log(9);
        check("clr_count", n_sw, GRID_CELLS);
        check("clr_order", sw_err, 0);
        check("clr_no_other", cpu_a.size(), 0);
        if (log_q.size() == GRID_CELLS) begin
            check("clr_first_cycle", log_q[0].c, start_cyc + 1);
            check("clr_consecutive", log_q[GRID_CELLS-1].c - log_q[0].c, GRID_CELLS - 1);
            check("clr_busy_last", 32'(log_q[GRID_CELLS-1].b), 0);
            check("clr_busy_prev", 32'(log_q[GRID_CELLS-2].b), 1);
        end
        check("clr_end_wren", 32'(wren_gridData), 0);
        check("clr_end_addr", 32'(wraddress_gridData), 32'hFFF);
        check("clr_end_data", 32'(data_gridData), 32'h9);

        // ---- clear with three CPU writes offered right after it starts
        do_reset();
        log_q.delete();
        clear_req   = 1'b1;
        clear_color = 4'hE;
        tick();
        start_cyc = cyc;
        clear_req = 1'b0;
        cpu_wren  = 1'b1;
        cpu_addr  = 12'h010;
        cpu_data  = 4'hA;
        tick();
        cpu_addr  = 12'h020;
        cpu_data  = 4'hB;
        tick();
        cpu_addr  = 12'h030;
        cpu_data  = 4'hC;
        tick();
        cpu_wren  = 1'b0;
        wait_sweep_end("cont");
        scan_log(14);
        check("cont_sweep_count", n_sw, GRID_CELLS);
        check("cont_sweep_order", sw_err, 0);
`ifdef GRID_ARB_FIFO_EN
        check("cont_cpu_count", cpu_a.size(), 3);
        check("cont_log_size", log_q.size(), GRID_CELLS + 3);
        check("cont_ovf", 32'(cpu_overflow), 0);
        if (log_q.size() == GRID_CELLS + 3) begin
            check("cont_first_cycle", log_q[0].c, start_cyc + 1);
            check("cont_span", log_q[GRID_CELLS+2].c - log_q[0].c, GRID_CELLS + 2);
            check("cont_slot1", log_q[1].a, 32'h010);
            check("cont_slot2", log_q[2].a, 1);
            check("cont_slot3", log_q[3].a, 32'h020);
            check("cont_slot4", log_q[4].a, 2);
            check("cont_slot5", log_q[5].a, 32'h030);
            check("cont_slot6", log_q[6].a, 3);
        end
`else
        check("cont_cpu_dropped", cpu_a.size(), 0);
        check("cont_log_size", log_q.size(), GRID_CELLS);
        check("cont_ovf", 32'(cpu_overflow), 1);
`endif

        // ---- overflow: ten back-to-back CPU writes during a sweep
        do_reset();
        log_q.delete();
        clear_req   = 1'b1;
        clear_color = 4'h0;
        tick();
        clear_req = 1'b0;
        ready_low = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_wren = 1'b1;
            cpu_addr = 12'(32'h800 + i);
            cpu_data = 4'(i + 1);
            if (cpu_ready === 1'b0) ready_low++;
            tick();
        end
        cpu_wren = 1'b0;
        check("ovf_set", 32'(cpu_overflow), 1);
        check("ovf_ready_low", ready_low, FIFO_EN ? 2 : 10);
        wait_sweep_end("ovf");
        scan_log(0);
        check("ovf_sweep_count", n_sw, GRID_CELLS);
        check("ovf_sweep_order", sw_err, 0);
`ifdef GRID_ARB_FIFO_EN
        check("ovf_cpu_count", cpu_a.size(), 8);
        if (cpu_a.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("ovf_cpu_%0d", i), cpu_a[i], exp_ovf[i]);
            end
        end
`else
        check("ovf_cpu_count", cpu_a.size(), 0);
`endif
        check("ovf_sticky", 32'(cpu_overflow), 1);
        check("ovf_ready_after", 32'(cpu_ready), 1);

        // ---- reset in the middle of a sweep, then restart
        do_reset();
        check("mid_ovf_cleared", 32'(cpu_overflow), 0);
        log_q.delete();
        clear_req   = 1'b1;
        clear_color = 4'h3;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!(wren_gridData === 1'b1 && wraddress_gridData == 12'd100) && n < 300) begin
            tick();
            n++;
        end
        check("mid_reach_100", 32'(wraddress_gridData), 100);
        reset = 1'b1;
        tick();
        check("mid_rst_wren", 32'(wren_gridData), 0);
        check("mid_rst_busy", 32'(clear_busy), 0);
        reset = 1'b0;
        tick();
        check("mid_idle_wren", 32'(wren_gridData), 0);
        clear_req   = 1'b1;
        clear_color = 4'h6;
        tick();
        clear_req = 1'b0;
        check("restart_busy", 32'(clear_busy), 1);
        tick();
        check("restart_wren", 32'(wren_gridData), 1);
        check("restart_addr", 32'(wraddress_gridData), 0);
        check("restart_data", 32'(data_gridData), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
